// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, constants and jump-target helper
package cpu_pkg;

  localparam logic [31:0] BUBBLE_INST = 32'hFC00_0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BUBBLE  = 6'h3F;

  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC mux: hold, redirect or sequential
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_write_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jump_base_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_set_o
);

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        unused_base;

  assign unused_base = ^jump_base_i[27:0];
  assign redirect    = pc_write_i & (branch_taken_i | jump_i);

  always_comb begin
    redirect_pc    = {branch_target_i[31:2], 2'b00};
    misalign_set_o = 1'b0;
    if (jump_i) begin
      redirect_pc = jump_target(jump_base_i[31:28], jump_index_i);
    end else if (redirect && branch_target_i[1:0] != 2'b00) begin
      // Low bits are dropped rather than trapping; the sticky flag records it.
      misalign_set_o = 1'b1;
    end

    next_pc_o = pc_i + 32'd4;
    if (!pc_write_i) begin
      next_pc_o = pc_i;
    end else if (redirect) begin
      next_pc_o = redirect_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, RUN/HALT fetch FSM and IF/ID controls
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jump_base_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        if_id_write_o,
  output logic        flush_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  next_pc;
  logic         misalign_set;
  logic         redirect;
  logic         next_oor;

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .pc_write_i      (pc_write_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jump_base_i     (jump_base_i),
    .next_pc_o       (next_pc),
    .misalign_set_o  (misalign_set)
  );

  assign redirect = pc_write_i & (branch_taken_i | jump_i);
  assign next_oor = {1'b0, next_pc} >= PC_LIMIT;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    misalign_d = misalign_q | misalign_set;
    inst_o     = inst_i;
    case (state_q)
      FETCH_RUN: begin
        pc_d = next_pc;
        if (next_oor) begin
          state_d = FETCH_HALT;
        end
        if (pc_write_i && !redirect) begin
          count_d = count_q + 32'd1;
        end
      end
      FETCH_HALT: begin
        // Only an in-range redirect restarts fetch; anything else keeps the PC parked.
        inst_o = BUBBLE_INST;
        if (redirect && !next_oor) begin
          pc_d    = next_pc;
          state_d = FETCH_RUN;
        end
      end
      default: begin
        state_d = FETCH_HALT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      count_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign inst_addr_o   = pc_q;
  assign if_id_write_o = pc_write_i;
  assign flush_o       = redirect;
  assign halted_o      = (state_q == FETCH_HALT);
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic [31:0] jump_base_i;
  logic [31:0] inst_i;

  logic [31:0] a_addr, a_inst, a_count;
  logic        a_ifid, a_flush, a_halt, a_mis;
  logic [31:0] b_addr, b_inst, b_count;
  logic        b_ifid, b_flush, b_halt, b_mis;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  always #5 clk_i = ~clk_i;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write_i(pc_write_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_index_i(jump_index_i), .jump_base_i(jump_base_i),
    .inst_i(inst_i), .inst_addr_o(a_addr), .inst_o(a_inst),
    .if_id_write_o(a_ifid), .flush_o(a_flush), .halted_o(a_halt),
    .misalign_o(a_mis), .fetch_count_o(a_count)
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write_i(pc_write_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_index_i(jump_index_i), .jump_base_i(jump_base_i),
    .inst_i(inst_i), .inst_addr_o(b_addr), .inst_o(b_inst),
    .if_id_write_o(b_ifid), .flush_o(b_flush), .halted_o(b_halt),
    .misalign_o(b_mis), .fetch_count_o(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; pc_write_i = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    jump_i = 1'b0; jump_index_i = 26'h0; jump_base_i = 32'h0; inst_i = 32'h1234_5678;
    step();
    rst_i = 1'b0;
    chk("rst_pc", a_addr, 32'h0);
    chk("rst_count", a_count, 32'h0);
    chk("rst_halt", {31'b0, a_halt}, 32'h0);
    chk("rst_mis", {31'b0, a_mis}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_pc", a_addr, 32'(i * 4));
      chk("seq_flush", {31'b0, a_flush}, 32'h0);
      chk("seq_inst", a_inst, 32'h1234_5678);
      step();
    end
    chk("seq_count", a_count, 32'd4);
    chk("seq_pc_end", a_addr, 32'h10);

    branch_taken_i = 1'b1; branch_target_i = 32'h40;
    #1;
    chk("br_flush", {31'b0, a_flush}, 32'h1);
    chk("br_ifid", {31'b0, a_ifid}, 32'h1);
    step();
    branch_taken_i = 1'b0;
    chk("br_pc", a_addr, 32'h40);
    chk("br_count", a_count, 32'd4);

    pc_write_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_flush", {31'b0, a_flush}, 32'h0);
      chk("stall_ifid", {31'b0, a_ifid}, 32'h0);
      step();
      chk("stall_pc", a_addr, 32'h40);
    end
    chk("stall_count", a_count, 32'd4);
    pc_write_i = 1'b1;
    #1;
    chk("release_flush", {31'b0, a_flush}, 32'h1);
    step();
    branch_taken_i = 1'b0;
    chk("release_pc", a_addr, 32'h80);
    chk("release_count", a_count, 32'd4);

    jump_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h100;
    jump_base_i = 32'h3000_0000; jump_index_i = 26'h10;
    step();
    jump_i = 1'b0; branch_taken_i = 1'b0;
    chk("jmp_pc", a_addr, 32'h3000_0040);
    chk("jmp_oor_halt", {31'b0, a_halt}, 32'h1);
    chk("jmp_halt_inst", a_inst, 32'hFC00_0000);
    chk("jmp_mis", {31'b0, a_mis}, 32'h0);

    branch_taken_i = 1'b1; branch_target_i = 32'h42;
    step();
    branch_taken_i = 1'b0;
    chk("mis_pc", a_addr, 32'h40);
    chk("mis_flag", {31'b0, a_mis}, 32'h1);
    chk("mis_run", {31'b0, a_halt}, 32'h0);
    chk("mis_count", a_count, 32'd4);
    step();
    step();
    chk("mis_seq_pc", a_addr, 32'h48);
    chk("mis_seq_count", a_count, 32'd6);
    chk("mis_sticky", {31'b0, a_mis}, 32'h1);

    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("b_rst_pc", b_addr, 32'h0);
    chk("a_rst_mis", {31'b0, a_mis}, 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("b_halt_pc", b_addr, 32'h10);
    chk("b_halted", {31'b0, b_halt}, 32'h1);
    chk("b_halt_inst", b_inst, 32'hFC00_0000);
    chk("b_halt_count", b_count, 32'd4);
    chk("a_run_inst", a_inst, 32'h1234_5678);
    step();
    chk("b_hold_pc", b_addr, 32'h10);
    chk("b_hold_count", b_count, 32'd4);

    branch_taken_i = 1'b1; branch_target_i = 32'h20;
    #1;
    chk("b_halt_flush", {31'b0, b_flush}, 32'h1);
    step();
    branch_taken_i = 1'b0;
    chk("b_oor_stay", {31'b0, b_halt}, 32'h1);
    chk("b_oor_pc", b_addr, 32'h10);

    jump_i = 1'b1; jump_base_i = 32'h0; jump_index_i = 26'h1;
    step();
    jump_i = 1'b0;
    chk("b_resume_halt", {31'b0, b_halt}, 32'h0);
    chk("b_resume_pc", b_addr, 32'h4);
    chk("b_resume_count", b_count, 32'd4);
    step();
    chk("b_run_pc", b_addr, 32'h8);
    chk("b_run_count", b_count, 32'd5);
    step();
    step();
    chk("b_rehalt", {31'b0, b_halt}, 32'h1);
    chk("b_rehalt_count", b_count, 32'd7);

    branch_taken_i = 1'b1; branch_target_i = 32'h43;
    step();
    branch_taken_i = 1'b0;
    chk("b_mis_halt", {31'b0, b_halt}, 32'h1);
    chk("b_mis_flag", {31'b0, b_mis}, 32'h1);
    chk("b_mis_pc", b_addr, 32'h10);

    rst_i = 1'b1; jump_i = 1'b1; jump_index_i = 26'h5;
    step();
    rst_i = 1'b0; jump_i = 1'b0;
    chk("rst2_pc", b_addr, 32'h0);
    chk("rst2_halt", {31'b0, b_halt}, 32'h0);
    chk("rst2_count", b_count, 32'h0);
    chk("rst2_mis", {31'b0, b_mis}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
